// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI command decoder and 8-bit register file (sys_clk domain).
// Ports:
//   sys_clk, rst (sync, active-high)
//   ss, data_rdy (async, synchronised)
//   spi_data_out: received byte
//   spi_data_in, data_latch: read-data load into the shifter
//   reg_q: flattened register file
//   wr_stb, wr_addr: write notification
//   addr_err: access to an address >= NUM_REGS
// Optional feature: define SPI_REG_BANK_AUTOINC_EN for burst (auto-increment)
// access until ss falls.
module spi_reg_bank #(
    parameter int NUM_REGS    = 16,
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  ss,
    input  logic                  data_rdy,
    input  logic [7:0]            spi_data_out,
    output logic [7:0]            spi_data_in,
    output logic                  data_latch,
    output logic [NUM_REGS*8-1:0] reg_q,
    output logic                  wr_stb,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic                  addr_err
);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WDATA,
        RDATA,
        DONE
    } state_t;

    localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

    state_t                   state_q;
    logic [SYNC_STAGES-1:0]   ss_sync_q;
    logic [SYNC_STAGES-1:0]   rdy_sync_q;
    logic                     ss_prev_q;
    logic                     rdy_prev_q;
    logic                     byte_stb_q;
    logic [ADDR_W-1:0]        addr_q;
    logic                     in_range_q;
    logic [7:0]               regs_q [NUM_REGS];
    logic [7:0]               spi_data_in_q;
    logic                     data_latch_q;
    logic                     wr_stb_q;
    logic [ADDR_W-1:0]        wr_addr_q;
    logic                     addr_err_q;

    logic                     ss_s;
    logic                     rdy_s;
    logic                     ss_rise;
    logic                     byte_stb_d;
    logic                     cmd_in_range;
    logic [ADDR_W-1:0]        cmd_addr;
    logic [7:0]               rd_data_d;

    assign ss_s       = ss_sync_q[SYNC_STAGES-1];
    assign rdy_s      = rdy_sync_q[SYNC_STAGES-1];
    assign ss_rise    = ss_s & ~ss_prev_q;
    assign byte_stb_d = rdy_s & ~rdy_prev_q;

    // Upper command address bits must be zero as well, so compare all 7.
    assign cmd_in_range = {1'b0, spi_data_out[6:0]} < NUM_REGS_B;
    assign cmd_addr     = spi_data_out[ADDR_W-1:0];
    assign rd_data_d    = cmd_in_range ? regs_q[cmd_addr] : 8'h00;

`ifdef SPI_REG_BANK_AUTOINC_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
    logic [ADDR_W-1:0] addr_nxt_d;
    logic [7:0]        rd_nxt_d;
    assign addr_nxt_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
    assign rd_nxt_d   = in_range_q ? regs_q[addr_nxt_d] : 8'h00;
`endif

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ss_sync_q     <= '0;
            rdy_sync_q    <= '0;
            ss_prev_q     <= 1'b0;
            rdy_prev_q    <= 1'b0;
            byte_stb_q    <= 1'b0;
            addr_q        <= '0;
            in_range_q    <= 1'b0;
            spi_data_in_q <= 8'h00;
            data_latch_q  <= 1'b0;
            wr_stb_q      <= 1'b0;
            wr_addr_q     <= '0;
            addr_err_q    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            ss_sync_q    <= {ss_sync_q[SYNC_STAGES-2:0], ss};
            rdy_sync_q   <= {rdy_sync_q[SYNC_STAGES-2:0], data_rdy};
            ss_prev_q    <= ss_s;
            rdy_prev_q   <= rdy_s;
            byte_stb_q   <= byte_stb_d;
            data_latch_q <= 1'b0;
            wr_stb_q     <= 1'b0;
            addr_err_q   <= 1'b0;

            // ss low has priority, so a byte arriving with the ss fall is dropped.
            if (!ss_s) begin
                state_q <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (ss_rise) begin
                            state_q <= CMD;
                        end
                    end
                    CMD: begin
                        if (byte_stb_q) begin
                            addr_q     <= cmd_addr;
                            in_range_q <= cmd_in_range;
                            if (spi_data_out[7]) begin
                                spi_data_in_q <= rd_data_d;
                                data_latch_q  <= 1'b1;
                                addr_err_q    <= ~cmd_in_range;
                                state_q       <= RDATA;
                            end else begin
                                state_q <= WDATA;
                            end
                        end
                    end
                    WDATA: begin
                        if (byte_stb_q) begin
                            if (in_range_q) begin
                                regs_q[addr_q] <= spi_data_out;
                                wr_stb_q       <= 1'b1;
                                wr_addr_q      <= addr_q;
                            end else begin
                                addr_err_q <= 1'b1;
                            end
`ifdef SPI_REG_BANK_AUTOINC_EN
                            addr_q <= addr_nxt_d;
`else
                            state_q <= DONE;
`endif
                        end
                    end
                    RDATA: begin
                        if (byte_stb_q) begin
`ifdef SPI_REG_BANK_AUTOINC_EN
                            // Preload the next register for the following byte.
                            addr_q        <= addr_nxt_d;
                            spi_data_in_q <= rd_nxt_d;
                            data_latch_q  <= 1'b1;
`else
                            state_q <= DONE;
`endif
                        end
                    end
                    DONE: begin
                        state_q <= DONE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_q[8*g +: 8] = regs_q[g];
    end

    assign spi_data_in = spi_data_in_q;
    assign data_latch  = data_latch_q;
    assign wr_stb      = wr_stb_q;
    assign wr_addr     = wr_addr_q;
    assign addr_err    = addr_err_q;

endmodule
